onehot_encoder_4x2: RTL and testbench
=====================================

# onehot_encoder_4x2

Registered 4-to-2 encoder with valid/ready handshake: the inverse of the team's 2x4 decoder. It accepts a 4-bit one-hot word and returns the 2-bit index that the decoder would have expanded. Non-one-hot words are flagged and counted. It sits downstream of decoder-based logic, so decoded lines can be folded back to a binary code across a pipeline boundary without dropping words under backpressure.

## Interface

Parameters:
- ERRCNT_W, default 8: width of the saturating error counter (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in  input  4  one-hot input word, in[3:0].
- out_valid  output  1  registered result present.
- out_ready  input  1  downstream accepts the result.
- out  output  2  encoded index.
- out_err  output  1  the word in the output register was not one-hot.
- err_cnt  output  ERRCNT_W  saturating count of accepted non-one-hot words.
- err_clr  input  1  synchronous clear of err_cnt.

## Operation

- Output stage is a single register with two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept occurs when in_valid && in_ready. On accept, out, out_err and out_valid=1 load on the next edge.
- Result drains when out_valid && out_ready.
- State transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on simultaneous drain and accept (back-to-back, no bubble).
  - FULL holds all outputs stable while out_ready=0.
- Encoding:
  - Exactly one bit set: out = index of that bit, out_err=0.
  - Two or more bits set: out = index of the highest set bit, out_err=1.
  - in=4'b0000: out=2'b00, out_err=1.
- Error counter:
  - Increments by 1 on each accept with out_err condition; this includes in=0.
  - Saturates at all-ones and never wraps.
  - err_clr=1 forces the counter to 0. If an erroring accept occurs in the same cycle, the counter becomes 1; the clear covers the count only up to the previous cycle.
- in is ignored whenever no accept occurs; X on in without in_valid must not corrupt state.

## Timing

- Reset values: out_valid=0, out=2'b00, out_err=0, err_cnt=0. in_ready=1 from the first cycle after reset.
- rst dominates every other input. Reset asserted while FULL discards the held word and does not count it.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- err_cnt updates on the same edge that loads the erroring word into the output register.
- No combinational path from in to any output. The only combinational output path is out_ready→in_ready.

## Structure

- Shared package enc_pkg:
  - Localparams ENC_IDX0..ENC_IDX3 (2'b00..2'b11).
  - ONEHOT_W=4.
  - IDX_W=2.
  - Reused by the 2x4 decoder for consistent bit ordering.
- One combinational sub-module, onehot_prio_enc:
  - in[3:0] → idx[1:0], err.
  - Contains all encoding and validity logic.
  - Kept separate so it can be formally checked against the decoder as an inverse pair.
- The top level holds the output register, handshake and counter only.

## Test plan

- Reset then single word: rst 2 cycles, send in=4'b0100 with out_ready=1 → next cycle out_valid=1, out=2'b10, out_err=0, err_cnt=0.
- Decoder round trip: for idx 0..3, drive decoder output into in → out equals idx, out_err=0, one result per cycle with no bubbles.
- Backpressure: out_ready=0 with in=4'b1000 accepted → out=2'b11 held for 5 cycles, in_ready=0. Release out_ready with a new word 4'b0001 pending → out=2'b00 next cycle, and the pending word is neither lost nor duplicated.
- Error words:
  - in=4'b0110 → out=2'b10, out_err=1, err_cnt=1.
  - Then in=4'b0000 → out=2'b00, out_err=1, err_cnt=2.
- Saturation and clear with ERRCNT_W=2:
  - Send 5 error words → err_cnt stays 3.
  - Assert err_clr alongside an error accept → err_cnt=1.
- Reset mid-operation: FULL with out_ready=0, assert rst → next cycle out_valid=0, err_cnt=0, in_ready=1, and the held word never appears on the output.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared encoder/decoder constants so the 2x4 decoder and the 4x2 encoder
// agree on bit ordering and widths.
package enc_pkg;

    localparam int ONEHOT_W = 4;
    localparam int IDX_W    = 2;

    localparam logic [IDX_W-1:0] ENC_IDX0 = 2'b00;
    localparam logic [IDX_W-1:0] ENC_IDX1 = 2'b01;
    localparam logic [IDX_W-1:0] ENC_IDX2 = 2'b10;
    localparam logic [IDX_W-1:0] ENC_IDX3 = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } outState_t;

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational priority encoder: returns the index of the highest set bit
// and flags any word that is not exactly one-hot (including all-zero).
module onehot_prio_enc
    import enc_pkg::*;
(
    input  logic [ONEHOT_W-1:0] in,
    output logic [IDX_W-1:0]    idx,
    output logic                err
);

    logic [ONEHOT_W-1:0] w_lowerBits;

    // A word is one-hot iff it is nonzero and clearing its lowest set bit leaves zero.
    assign w_lowerBits = in & (in - ONEHOT_W'(1));

    always_comb begin
        idx = ENC_IDX0;
        if (in[3])
            idx = ENC_IDX3;
        else if (in[2])
            idx = ENC_IDX2;
        else if (in[1])
            idx = ENC_IDX1;
        err = (in == '0) || (w_lowerBits != '0);
    end

endmodule

// File: rtl/onehot_encoder_4x2.sv
// Registered 4-to-2 one-hot encoder with a single-entry valid/ready output
// stage and a saturating count of accepted non-one-hot words.
module onehot_encoder_4x2
    import enc_pkg::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ONEHOT_W-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_clr
);

    outState_t           r_state;
    logic [IDX_W-1:0]    r_out;
    logic                r_outErr;
    logic [ERRCNT_W-1:0] r_errCnt;

    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_accept;
    logic                w_errAccept;

    onehot_prio_enc u_prioEnc (
        .in  (in),
        .idx (w_idx),
        .err (w_err)
    );

    // Accepting while full is allowed when the held word drains the same cycle.
    assign in_ready    = (r_state == ST_EMPTY) || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_errAccept = w_accept && w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_out    <= ENC_IDX0;
            r_outErr <= 1'b0;
        end else if (w_accept) begin
            r_state  <= ST_FULL;
            r_out    <= w_idx;
            r_outErr <= w_err;
        end else if (r_state == ST_FULL && out_ready) begin
            r_state  <= ST_EMPTY;
        end
    end

    // Clear wipes history up to last cycle; an erroring accept this cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errCnt <= '0;
        end else if (err_clr) begin
            r_errCnt <= w_errAccept ? ERRCNT_W'(1) : '0;
        end else if (w_errAccept && (r_errCnt != '1)) begin
            r_errCnt <= r_errCnt + ERRCNT_W'(1);
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out       = r_out;
    assign out_err   = r_outErr;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_onehot_encoder_4x2.sv
// Directed bench for onehot_encoder_4x2: a default-width instance and a
// 2-bit-counter instance share the same stimulus.
module tb_onehot_encoder_4x2;

    logic       clock = 1'b0;
    logic       rst;
    logic       inValid;
    logic [3:0] inWord;
    logic       outReady;
    logic       errClr;

    logic       inReady,  inReadyS;
    logic       outValid, outValidS;
    logic [1:0] outIdx,   outIdxS;
    logic       outErr,   outErrS;
    logic [7:0] errCnt;
    logic [1:0] errCntS;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clock = ~clock;

    onehot_encoder_4x2 #(.ERRCNT_W(8)) dut (
        .clk       (clock),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in        (inWord),
        .out_valid (outValid),
        .out_ready (outReady),
        .out       (outIdx),
        .out_err   (outErr),
        .err_cnt   (errCnt),
        .err_clr   (errClr)
    );

    onehot_encoder_4x2 #(.ERRCNT_W(2)) dutSat (
        .clk       (clock),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReadyS),
        .in        (inWord),
        .out_valid (outValidS),
        .out_ready (outReady),
        .out       (outIdxS),
        .out_err   (outErrS),
        .err_cnt   (errCntS),
        .err_clr   (errClr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, then wait until just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] w, input logic rdy, input logic clr);
        inValid  = v;
        inWord   = w;
        outReady = rdy;
        errClr   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic v, input logic [1:0] idx, input logic e);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'(v));
        checkOutput({tag, ".out"},   32'(outIdx),   32'(idx));
        checkOutput({tag, ".err"},   32'(outErr),   32'(e));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkResult("reset", 1'b0, 2'b00, 1'b0);
        checkOutput("reset.cnt",   32'(errCnt),  0);
        checkOutput("reset.ready", 32'(inReady), 1);

        applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
        checkResult("single", 1'b1, 2'b10, 1'b0);
        checkOutput("single.cnt", 32'(errCnt), 0);

        // Back-to-back round trip; out_valid must stay high every cycle.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] decoded;
            decoded = 4'b0001 << i;
            applyStimulus(1'b1, decoded, 1'b1, 1'b0);
            checkResult($sformatf("trip%0d", i), 1'b1, 2'(i), 1'b0);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("trip.drain", 32'(outValid), 0);

        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        inWord = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            checkResult($sformatf("hold%0d", i), 1'b1, 2'b11, 1'b0);
            checkOutput($sformatf("hold%0d.ready", i), 32'(inReady), 0);
            @(posedge clock);
            #1;
        end
        outReady = 1'b1;
        #1;
        checkOutput("release.ready", 32'(inReady), 1);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        checkResult("release", 1'b1, 2'b00, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("nodup.valid", 32'(outValid), 0);

        applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
        checkResult("err0110", 1'b1, 2'b10, 1'b1);
        checkOutput("err0110.cnt",  32'(errCnt),  1);
        checkOutput("err0110.cntS", 32'(errCntS), 1);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        checkResult("err0000", 1'b1, 2'b00, 1'b1);
        checkOutput("err0000.cnt",  32'(errCnt),  2);
        checkOutput("err0000.cntS", 32'(errCntS), 2);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkResult("err1111", 1'b1, 2'b11, 1'b1);
        checkOutput("sat.cnt",  32'(errCnt),  7);
        checkOutput("sat.cntS", 32'(errCntS), 3);

        applyStimulus(1'b1, 4'b0011, 1'b1, 1'b1);
        checkResult("clrErr", 1'b1, 2'b01, 1'b1);
        checkOutput("clrErr.cnt",  32'(errCnt),  1);
        checkOutput("clrErr.cntS", 32'(errCntS), 1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        checkOutput("clrOnly.cnt",   32'(errCnt),   0);
        checkOutput("clrOnly.valid", 32'(outValid), 0);

        // Garbage on in without in_valid must leave everything untouched.
        applyStimulus(1'b0, 4'b1011, 1'b1, 1'b0);
        checkResult("idle", 1'b0, 2'b01, 1'b1);
        checkOutput("idle.cnt", 32'(errCnt), 0);

        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        checkResult("preRst", 1'b1, 2'b01, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0);
        checkResult("midRst", 1'b0, 2'b00, 1'b0);
        checkOutput("midRst.cnt",   32'(errCnt),  0);
        checkOutput("midRst.ready", 32'(inReady), 1);
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("postRst.valid", 32'(outValid), 0);
        checkOutput("postRst.cntS",  32'(errCntS),  0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
